centroid_accum: RTL and testbench

Parametrised per-cluster centroid engine for the blob-tracking path, and the successor to the fixed four-cluster accumulator. It accumulates pixel coordinates into K clusters, and on a tabulate request snapshots the sums into a double buffer. A single shared serial divider then computes every centroid while the next frame keeps accumulating. Results go to the overlay and tracking logic with an area-threshold presence flag and a single frame-level valid strobe.

---
 rtl/centroid_accum.sv | 242 ++++++++++++++++++++++++
 tb/tb_centroid_accum.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/centroid_accum.sv
// rtl/centroid_accum.sv - K-cluster pixel accumulator with double-buffered serial centroid divider
// Optional feature: define CENTROID_BBOX_EN for per-cluster bounding-box outputs.
module centroid_accum #(
  parameter int K          = 4,
  parameter int X_WIDTH    = 11,
  parameter int Y_WIDTH    = 10,
  parameter int AREA_WIDTH = 20,
  parameter int SUM_WIDTH  = 32
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [X_WIDTH-1:0]     x_in,
  input  logic [Y_WIDTH-1:0]     y_in,
  input  logic [$clog2(K)-1:0]   cluster_in,
  input  logic                   valid_in,
  input  logic                   tabulate_in,
  input  logic [AREA_WIDTH-1:0]  min_area_in,
  output logic [X_WIDTH-1:0]     x_out [K],
  output logic [Y_WIDTH-1:0]     y_out [K],
  output logic [AREA_WIDTH-1:0]  area_out [K],
  output logic                   present_out [K],
`ifdef CENTROID_BBOX_EN
  output logic [X_WIDTH-1:0]     xmin_out [K],
  output logic [X_WIDTH-1:0]     xmax_out [K],
  output logic [Y_WIDTH-1:0]     ymin_out [K],
  output logic [Y_WIDTH-1:0]     ymax_out [K],
`endif
  output logic                   valid_out,
  output logic                   busy_out,
  output logic                   overrun_out
);

  localparam int OPS = 2 * K;
  localparam int OW  = $clog2(OPS);
  localparam int BW  = $clog2(SUM_WIDTH);
  localparam int QW  = (X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH;
  localparam logic [OW-1:0] LAST_OP  = OW'(OPS - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(SUM_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;
  state_t state;

  logic [SUM_WIDTH-1:0]  sum_x [K], sum_y [K], nsum_x [K], nsum_y [K];
  logic [AREA_WIDTH-1:0] cnt [K], ncnt [K];
  logic [SUM_WIDTH-1:0]  sh_x [K], sh_y [K];
  logic [AREA_WIDTH-1:0] sh_cnt [K];
  logic [AREA_WIDTH-1:0] sh_min;
  logic                  accept;

  assign busy_out = (state == LOAD) || (state == ITER);
  assign accept   = tabulate_in && !busy_out;

  // A saturated cluster drops the whole pixel so the sums can never wrap.
  always_comb begin
    for (int k = 0; k < K; k++) begin
      nsum_x[k] = sum_x[k];
      nsum_y[k] = sum_y[k];
      ncnt[k]   = cnt[k];
      if (valid_in && int'(cluster_in) == k && cnt[k] != {AREA_WIDTH{1'b1}}) begin
        nsum_x[k] = sum_x[k] + SUM_WIDTH'(x_in);
        nsum_y[k] = sum_y[k] + SUM_WIDTH'(y_in);
        ncnt[k]   = cnt[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int k = 0; k < K; k++) begin
        sum_x[k]  <= '0;
        sum_y[k]  <= '0;
        cnt[k]    <= '0;
        sh_x[k]   <= '0;
        sh_y[k]   <= '0;
        sh_cnt[k] <= '0;
      end
      sh_min      <= '0;
      overrun_out <= 1'b0;
    end else begin
      overrun_out <= tabulate_in && busy_out;
      for (int k = 0; k < K; k++) begin
        if (accept) begin
          sh_x[k]   <= nsum_x[k];
          sh_y[k]   <= nsum_y[k];
          sh_cnt[k] <= ncnt[k];
          sum_x[k]  <= '0;
          sum_y[k]  <= '0;
          cnt[k]    <= '0;
        end else begin
          sum_x[k]  <= nsum_x[k];
          sum_y[k]  <= nsum_y[k];
          cnt[k]    <= ncnt[k];
        end
      end
      if (accept) sh_min <= min_area_in;
    end
  end

`ifdef CENTROID_BBOX_EN
  logic [X_WIDTH-1:0] lxmin [K], lxmax [K], nxmin [K], nxmax [K], sxmin [K], sxmax [K];
  logic [Y_WIDTH-1:0] lymin [K], lymax [K], nymin [K], nymax [K], symin [K], symax [K];

  always_comb begin
    for (int k = 0; k < K; k++) begin
      nxmin[k] = lxmin[k];
      nxmax[k] = lxmax[k];
      nymin[k] = lymin[k];
      nymax[k] = lymax[k];
      if (valid_in && int'(cluster_in) == k && cnt[k] != {AREA_WIDTH{1'b1}}) begin
        if (x_in < lxmin[k]) nxmin[k] = x_in;
        if (x_in > lxmax[k]) nxmax[k] = x_in;
        if (y_in < lymin[k]) nymin[k] = y_in;
        if (y_in > lymax[k]) nymax[k] = y_in;
      end
    end
  end

  // Empty live box is min=all-ones, max=0 so the first pixel always wins.
  always_ff @(posedge clk_in) begin
    for (int k = 0; k < K; k++) begin
      if (rst_in || accept) begin
        lxmin[k] <= '1;
        lxmax[k] <= '0;
        lymin[k] <= '1;
        lymax[k] <= '0;
      end else begin
        lxmin[k] <= nxmin[k];
        lxmax[k] <= nxmax[k];
        lymin[k] <= nymin[k];
        lymax[k] <= nymax[k];
      end
      if (rst_in) begin
        sxmin[k] <= '1;
        sxmax[k] <= '0;
        symin[k] <= '1;
        symax[k] <= '0;
      end else if (accept) begin
        sxmin[k] <= nxmin[k];
        sxmax[k] <= nxmax[k];
        symin[k] <= nymin[k];
        symax[k] <= nymax[k];
      end
    end
  end
`endif

  logic [OW-1:0]        op_idx;
  logic [BW-1:0]        bit_cnt;
  logic [SUM_WIDTH-1:0] dvd, den, rem, dvd_nx, rem_nx;
  logic [SUM_WIDTH:0]   trial;
  logic [QW-1:0]        q_buf [OPS];
  logic [QW-1:0]        q_fin [OPS];
  logic [QW-1:0]        q_now;

  // One restoring step: quotient bits shift into the dividend register.
  always_comb begin
    trial = {rem, dvd[SUM_WIDTH-1]} - {1'b0, den};
    if (!trial[SUM_WIDTH]) begin
      rem_nx = trial[SUM_WIDTH-1:0];
      dvd_nx = {dvd[SUM_WIDTH-2:0], 1'b1};
    end else begin
      rem_nx = {rem[SUM_WIDTH-2:0], dvd[SUM_WIDTH-1]};
      dvd_nx = {dvd[SUM_WIDTH-2:0], 1'b0};
    end
  end

  assign q_now = (den == '0) ? '0 : dvd_nx[QW-1:0];

  always_comb begin
    for (int i = 0; i < OPS; i++) begin
      q_fin[i] = (op_idx == OW'(i)) ? q_now : q_buf[i];
    end
  end

  always_ff @(posedge clk_in) begin
    valid_out <= 1'b0;
    if (rst_in) begin
      state   <= IDLE;
      op_idx  <= '0;
      bit_cnt <= '0;
      dvd     <= '0;
      den     <= '0;
      rem     <= '0;
      for (int i = 0; i < OPS; i++) q_buf[i] <= '0;
      for (int k = 0; k < K; k++) begin
        x_out[k]       <= '0;
        y_out[k]       <= '0;
        area_out[k]    <= '0;
        present_out[k] <= 1'b0;
`ifdef CENTROID_BBOX_EN
        xmin_out[k]    <= '0;
        xmax_out[k]    <= '0;
        ymin_out[k]    <= '0;
        ymax_out[k]    <= '0;
`endif
      end
    end else begin
      case (state)
        IDLE, DONE: begin
          op_idx <= '0;
          state  <= tabulate_in ? LOAD : IDLE;
        end
        LOAD: begin
          dvd     <= op_idx[0] ? sh_y[op_idx[OW-1:1]] : sh_x[op_idx[OW-1:1]];
          den     <= SUM_WIDTH'(sh_cnt[op_idx[OW-1:1]]);
          rem     <= '0;
          bit_cnt <= '0;
          state   <= ITER;
        end
        ITER: begin
          dvd     <= dvd_nx;
          rem     <= rem_nx;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            q_buf[op_idx] <= q_now;
            if (op_idx == LAST_OP) begin
              for (int k = 0; k < K; k++) begin
                x_out[k]       <= q_fin[2*k][X_WIDTH-1:0];
                y_out[k]       <= q_fin[2*k+1][Y_WIDTH-1:0];
                area_out[k]    <= sh_cnt[k];
                present_out[k] <= (sh_cnt[k] != '0) && (sh_cnt[k] >= sh_min);
`ifdef CENTROID_BBOX_EN
                xmin_out[k]    <= sxmin[k];
                xmax_out[k]    <= sxmax[k];
                ymin_out[k]    <= symin[k];
                ymax_out[k]    <= symax[k];
`endif
              end
              valid_out <= 1'b1;
              state     <= DONE;
            end else begin
              op_idx <= op_idx + 1'b1;
              state  <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_centroid_accum.sv
// tb/tb_centroid_accum.sv - scoreboard bench for centroid_accum with directed frames
module tb_centroid_accum;
  localparam int K = 4;
  localparam int LAT = 265;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] x_in = '0;
  logic [9:0]  y_in = '0;
  logic [1:0]  cl = '0;
  logic        valid_in = 1'b0;
  logic        tab = 1'b0;
  logic [19:0] min_area = 20'd1;
  logic [10:0] x_out [K];
  logic [9:0]  y_out [K];
  logic [19:0] area_out [K];
  logic        present_out [K];
  logic        valid_out, busy_out, overrun_out;
`ifdef CENTROID_BBOX_EN
  logic [10:0] xmin_out [K], xmax_out [K];
  logic [9:0]  ymin_out [K], ymax_out [K];
`endif

  centroid_accum dut (
    .clk_in(clk), .rst_in(rst), .x_in(x_in), .y_in(y_in), .cluster_in(cl),
    .valid_in(valid_in), .tabulate_in(tab), .min_area_in(min_area),
    .x_out(x_out), .y_out(y_out), .area_out(area_out), .present_out(present_out),
`ifdef CENTROID_BBOX_EN
    .xmin_out(xmin_out), .xmax_out(xmax_out), .ymin_out(ymin_out), .ymax_out(ymax_out),
`endif
    .valid_out(valid_out), .busy_out(busy_out), .overrun_out(overrun_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0]       vcyc;
    logic [3:0][10:0]  x;
    logic [3:0][9:0]   y;
    logic [3:0][19:0]  a;
    logic [3:0]        p;
  } exp_t;

  exp_t sb [$];
  exp_t me;
  int e_x [K], e_y [K], e_a [K], e_p [K];
  int vectors = 0, miscompares = 0;
  int ovr_n = 0, ovr_cyc = -1;
  int t, t0, tb_t;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clr_exp();
    for (int k = 0; k < K; k++) begin
      e_x[k] = 0; e_y[k] = 0; e_a[k] = 0; e_p[k] = 0;
    end
  endtask

  task automatic push_exp(input int vc);
    exp_t e;
    e.vcyc = 32'(vc);
    for (int k = 0; k < K; k++) begin
      e.x[k] = 11'(e_x[k]);
      e.y[k] = 10'(e_y[k]);
      e.a[k] = 20'(e_a[k]);
      e.p[k] = e_p[k][0];
    end
    sb.push_back(e);
  endtask

  task automatic at_cycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step();
    at_cycle(cyc + 1);
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 3000) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    for (int k = 0; k < K; k++) begin
      chk($sformatf("%s_x%0d", tag, k), int'(x_out[k]), 0);
      chk($sformatf("%s_y%0d", tag, k), int'(y_out[k]), 0);
      chk($sformatf("%s_area%0d", tag, k), int'(area_out[k]), 0);
      chk($sformatf("%s_present%0d", tag, k), int'(present_out[k]), 0);
    end
    chk($sformatf("%s_busy", tag), int'(busy_out), 0);
    chk($sformatf("%s_valid", tag), int'(valid_out), 0);
  endtask

  // Monitor: every valid_out strobe is matched against the oldest expected frame.
  always @(negedge clk) begin
    if (overrun_out) begin
      ovr_n++;
      ovr_cyc = cyc;
    end
    if (valid_out) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid_cycle", cyc, -1);
      end else begin
        me = sb.pop_front();
        chk("valid_cycle", cyc, int'(me.vcyc));
        for (int k = 0; k < K; k++) begin
          chk($sformatf("x%0d", k), int'(x_out[k]), int'(me.x[k]));
          chk($sformatf("y%0d", k), int'(y_out[k]), int'(me.y[k]));
          chk($sformatf("area%0d", k), int'(area_out[k]), int'(me.a[k]));
          chk($sformatf("present%0d", k), int'(present_out[k]), int'(me.p[k]));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    at_cycle(3);
    rst = 1'b0;
    @(negedge clk);
    chk_zero_outputs("reset");

    // Single pixel to cluster 2, busy window edges and fixed latency.
    step();
    valid_in = 1; x_in = 100; y_in = 50; cl = 2;
    step();
    valid_in = 0; tab = 1; t = cyc;
    clr_exp(); e_x[2] = 100; e_y[2] = 50; e_a[2] = 1; e_p[2] = 1;
    push_exp(t + LAT);
    step();
    tab = 0;
    @(negedge clk); chk("busy_first", int'(busy_out), 1);
    at_cycle(t + 264); @(negedge clk); chk("busy_last", int'(busy_out), 1);
    at_cycle(t + 265); @(negedge clk); chk("busy_in_valid_cycle", int'(busy_out), 0);
    drain();

    // Truncating mean and threshold above area.
    step();
    min_area = 4;
    valid_in = 1; cl = 0; x_in = 10; y_in = 4;
    step(); x_in = 11; y_in = 4;
    step(); x_in = 13; y_in = 5;
    step(); valid_in = 0; tab = 1; t = cyc;
    clr_exp(); e_x[0] = 11; e_y[0] = 4; e_a[0] = 3; e_p[0] = 0;
    push_exp(t + LAT);
    step(); tab = 0; min_area = 1;
    drain();

    // Pixel in the tabulate cycle lands in the snapshot; the following frame is empty.
    step();
    valid_in = 1; cl = 1; x_in = 20; y_in = 20; tab = 1; t = cyc;
    clr_exp(); e_x[1] = 20; e_y[1] = 20; e_a[1] = 1; e_p[1] = 1;
    push_exp(t + LAT);
    step(); valid_in = 0; tab = 0;
    drain();
    step();
    tab = 1; t = cyc;
    clr_exp(); push_exp(t + LAT);
    step(); tab = 0;
    drain();

    // 1000 pixels accumulate through a busy period; next tabulate lands on a valid_out cycle.
    step();
    tab = 1; t0 = cyc;
    clr_exp(); push_exp(t0 + LAT);
    step(); tab = 0;
    for (int i = 0; i < 1000; i++) begin
      valid_in = 1; cl = 3;
      x_in = (i % 2 == 1) ? 11'd301 : 11'd300;
      y_in = (i % 2 == 1) ? 10'd43 : 10'd40;
      if (i == 999) begin
        tab = 1; tb_t = cyc;
      end
      step();
    end
    valid_in = 0; tab = 0;
    clr_exp(); e_x[3] = 300; e_y[3] = 41; e_a[3] = 1000; e_p[3] = 1;
    push_exp(tb_t + LAT);
    at_cycle(tb_t + LAT);
    tab = 1; t = cyc;
    clr_exp(); push_exp(t + LAT);
    step(); tab = 0;
    drain();

    // Tabulate while busy: one overrun strobe, one result.
    step();
    valid_in = 1; cl = 3; x_in = 7; y_in = 3;
    step();
    valid_in = 0; tab = 1; t = cyc;
    clr_exp(); e_x[3] = 7; e_y[3] = 3; e_a[3] = 1; e_p[3] = 1;
    push_exp(t + LAT);
    step(); tab = 0;
    at_cycle(t + 10); tab = 1;
    step(); tab = 0;
    drain();
    at_cycle(cyc + 300);
    chk("overrun_count", ovr_n, 1);
    chk("overrun_cycle", ovr_cyc, t + 11);

    // Reset in mid-divide aborts the frame and clears outputs and live sums.
    step();
    valid_in = 1; cl = 0; x_in = 5; y_in = 6; tab = 1; t = cyc;
    step(); valid_in = 0; tab = 0;
    at_cycle(t + 50); valid_in = 1; cl = 1; x_in = 9; y_in = 9;
    step(); valid_in = 0;
    at_cycle(t + 100); rst = 1;
    step(); rst = 0;
    @(negedge clk);
    chk_zero_outputs("midreset");
    at_cycle(cyc + 300);
    tab = 1; t = cyc;
    clr_exp(); push_exp(t + LAT);
    step(); tab = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
